// File: rtl/life_pkg.sv
// Shared constants and types for the Game of Life grid sequencer.
package life_pkg;

    localparam int unsigned COLS     = 80;
    localparam int unsigned ROWS     = 48;
    localparam int unsigned CELLS    = COLS * ROWS;
    localparam int unsigned ADDR_W   = $clog2(CELLS);
    localparam int unsigned DIV_W    = 24;
    localparam int unsigned GEN_W    = 16;
    localparam int unsigned SETTLE   = 2;
    localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
    // Wide enough for 255*COLS + 255 so out-of-range edits never alias.
    localparam int unsigned FULL_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    // Row-major cell index, computed at full width before any truncation.
    function automatic logic [FULL_W-1:0] cell_index(input logic [7:0] x, input logic [7:0] y);
        return FULL_W'(FULL_W'(y) * FULL_W'(COLS) + FULL_W'(x));
    endfunction

endpackage

// File: rtl/life_rate_timer.sv
// Generation rate timer: counts 0..max(period,1)-1 while run_en and raises
// tick_pend on terminal count; tick_pend holds until consumed or run_en drops.
// Ports: clk, reset (sync, active-high), run_en, period, tick_clr (consume),
//        tick_pend (pending timed generation).
module life_rate_timer
    import life_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic [DIV_W-1:0] period,
    input  logic             tick_clr,
    output logic             tick_pend
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last;
    logic             tick_d;

    // Period 0 behaves like period 1; >= guards against period shrinking mid-count.
    always_comb begin
        cnt_d  = cnt;
        tick_d = tick_pend && !tick_clr;
        last   = (period == '0) ? '0 : period - DIV_W'(1);
        if (!run_en) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt >= last) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            tick_pend <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            tick_pend <= tick_d;
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Sequences the Life grid datapath: each clock the grid is cleared, written
// with one edited cell, advanced one generation, or left alone.
// Ports: clk, reset (sync, active-high); run_en/period (free-run timer);
//        step_req, clear_req (one-cycle pulses); edit_valid/edit_ready with
//        edit_x/edit_y/edit_val; edit_err; grid_we/grid_addr/grid_wdata,
//        grid_load_next, grid_clear strobes; gen_count; busy.
// All outputs are registered and change together with the state register.
module life_sequencer
    import life_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic [DIV_W-1:0]  period,
    input  logic              step_req,
    input  logic              clear_req,
    input  logic              edit_valid,
    output logic              edit_ready,
    input  logic [7:0]        edit_x,
    input  logic [7:0]        edit_y,
    input  logic              edit_val,
    output logic              edit_err,
    output logic              grid_we,
    output logic [ADDR_W-1:0] grid_addr,
    output logic              grid_wdata,
    output logic              grid_load_next,
    output logic              grid_clear,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy
);

    state_t              state, state_d;
    logic [SETTLE_W-1:0] settle_cnt, settle_d;
    logic                clear_pend, clear_pend_d;
    logic                step_pend, step_pend_d;
    logic                tick_pend;
    logic                go_clear, go_load, accept;
    logic                in_range;
    logic [FULL_W-1:0]   full_idx;
    logic [GEN_W-1:0]    gen_d;
    logic                we_d, err_d, wdata_d, ready_d, busy_d;
    logic [ADDR_W-1:0]   addr_d;

    life_rate_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .run_en    (run_en),
        .period    (period),
        .tick_clr  (go_clear || go_load),
        .tick_pend (tick_pend)
    );

    assign in_range = (32'(edit_x) < COLS) && (32'(edit_y) < ROWS);
    assign full_idx = cell_index(edit_x, edit_y);

    // Next state, pending flags and registered strobe values.
    always_comb begin
        state_d  = state;
        settle_d = settle_cnt;
        go_clear = 1'b0;
        go_load  = 1'b0;
        accept   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (clear_pend) begin
                    go_clear = 1'b1;
                    state_d  = ST_CLEAR;
                end else if (edit_valid && edit_ready) begin
                    accept   = 1'b1;
                    state_d  = ST_WRITE;
                end else if (step_pend || tick_pend) begin
                    go_load  = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_WRITE, ST_LOAD, ST_CLEAR: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_W'(SETTLE - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_cnt + SETTLE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        clear_pend_d = (clear_pend && !go_clear) || clear_req;
        // A step arriving with a clear is discarded: the clear wins.
        step_pend_d  = ((step_pend && !(go_clear || go_load)) || step_req) && !clear_req;

        gen_d = gen_count;
        if (go_clear) begin
            gen_d = '0;
        end else if (go_load) begin
            gen_d = gen_count + GEN_W'(1);
        end

        we_d    = accept && in_range;
        err_d   = accept && !in_range;
        addr_d  = we_d ? ADDR_W'(full_idx) : '0;
        wdata_d = we_d && edit_val;
        ready_d = (state_d == ST_IDLE) && !clear_pend_d;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            settle_cnt     <= '0;
            clear_pend     <= 1'b0;
            step_pend      <= 1'b0;
            gen_count      <= '0;
            edit_ready     <= 1'b0;
            edit_err       <= 1'b0;
            grid_we        <= 1'b0;
            grid_addr      <= '0;
            grid_wdata     <= 1'b0;
            grid_load_next <= 1'b0;
            grid_clear     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            settle_cnt     <= settle_d;
            clear_pend     <= clear_pend_d;
            step_pend      <= step_pend_d;
            gen_count      <= gen_d;
            edit_ready     <= ready_d;
            edit_err       <= err_d;
            grid_we        <= we_d;
            grid_addr      <= addr_d;
            grid_wdata     <= wdata_d;
            grid_load_next <= go_load;
            grid_clear     <= go_clear;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboard bench for life_sequencer: stimulus pushes expected strobes
// (with the cycle they must appear in); a negedge monitor pops and compares.
module tb_life_sequencer;
    import life_pkg::*;

    localparam logic [3:0] K_WE    = 4'b1000;
    localparam logic [3:0] K_ERR   = 4'b0100;
    localparam logic [3:0] K_LOAD  = 4'b0010;
    localparam logic [3:0] K_CLEAR = 4'b0001;

    typedef struct packed {
        logic [3:0]        strobes;
        logic [31:0]       cyc;
        logic [ADDR_W-1:0] addr;
        logic              wdata;
        logic [GEN_W-1:0]  gen;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              run_en;
    logic [DIV_W-1:0]  period;
    logic              step_req;
    logic              clear_req;
    logic              edit_valid;
    logic              edit_ready;
    logic [7:0]        edit_x;
    logic [7:0]        edit_y;
    logic              edit_val;
    logic              edit_err;
    logic              grid_we;
    logic [ADDR_W-1:0] grid_addr;
    logic              grid_wdata;
    logic              grid_load_next;
    logic              grid_clear;
    logic [GEN_W-1:0]  gen_count;
    logic              busy;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    ev_t exp_q[$];

    life_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .run_en         (run_en),
        .period         (period),
        .step_req       (step_req),
        .clear_req      (clear_req),
        .edit_valid     (edit_valid),
        .edit_ready     (edit_ready),
        .edit_x         (edit_x),
        .edit_y         (edit_y),
        .edit_val       (edit_val),
        .edit_err       (edit_err),
        .grid_we        (grid_we),
        .grid_addr      (grid_addr),
        .grid_wdata     (grid_wdata),
        .grid_load_next (grid_load_next),
        .grid_clear     (grid_clear),
        .gen_count      (gen_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        ev_t act, e;
        if (grid_we || edit_err || grid_load_next || grid_clear) begin
            act = '{strobes: {grid_we, edit_err, grid_load_next, grid_clear},
                    cyc: 32'(cyc), addr: grid_addr, wdata: grid_wdata, gen: gen_count};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d strobes=%b addr=%0d gen=%0d required none",
                         cyc, act.strobes, act.addr, act.gen);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL strobe_event got strobes=%b cyc=%0d addr=%0d wdata=%b gen=%0d required strobes=%b cyc=%0d addr=%0d wdata=%b gen=%0d",
                             act.strobes, act.cyc, act.addr, act.wdata, act.gen,
                             e.strobes, e.cyc, e.addr, e.wdata, e.gen);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input logic [3:0] k, input int at, input int addr,
                             input logic wdata, input int gen);
        exp_q.push_back('{strobes: k, cyc: 32'(at), addr: ADDR_W'(addr), wdata: wdata, gen: GEN_W'(gen)});
    endtask

    // Single edit from IDLE; DUT back in IDLE four cycles later.
    task automatic do_edit(input int x, input int y, input logic v, input logic ok,
                           input int addr, input int gen);
        check("edit_ready_idle", 32'(edit_ready), 1);
        if (ok) expect_ev(K_WE, cyc + 1, addr, v, gen);
        else    expect_ev(K_ERR, cyc + 1, 0, 1'b0, gen);
        edit_x = 8'(x); edit_y = 8'(y); edit_val = v; edit_valid = 1'b1;
        tick();
        edit_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int t;
        reset = 1'b1; run_en = 1'b0; period = 24'd10; step_req = 1'b0;
        clear_req = 1'b0; edit_valid = 1'b0; edit_x = '0; edit_y = '0; edit_val = 1'b0;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_gen", 32'(gen_count), 0);
        check("reset_ready", 32'(edit_ready), 0);
        check("reset_strobes", 32'({grid_we, edit_err, grid_load_next, grid_clear, grid_wdata}), 0);
        check("reset_addr", 32'(grid_addr), 0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", 32'(edit_ready), 1);

        // Single step: load two cycles after the pulse.
        expect_ev(K_LOAD, cyc + 2, 0, 1'b0, 1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (6) tick();
        check("gen_after_step", 32'(gen_count), 1);
        check("idle_after_step", 32'(busy), 0);

        // Edit (5,2)=1: address 165, ready low for 1+SETTLE cycles.
        check("edit_ready_idle", 32'(edit_ready), 1);
        expect_ev(K_WE, cyc + 1, 165, 1'b1, 1);
        edit_x = 8'd5; edit_y = 8'd2; edit_val = 1'b1; edit_valid = 1'b1;
        tick();
        edit_valid = 1'b0;
        check("ready_low_write", 32'(edit_ready), 0);
        check("busy_write", 32'(busy), 1);
        tick(); tick();
        check("ready_low_settle_end", 32'(edit_ready), 0);
        tick();
        check("ready_back", 32'(edit_ready), 1);

        // Range boundaries.
        do_edit(80, 0, 1'b1, 1'b0, 0, 1);
        do_edit(0, 48, 1'b1, 1'b0, 0, 1);
        do_edit(79, 47, 1'b1, 1'b1, 3839, 1);
        do_edit(0, 0, 1'b0, 1'b1, 0, 1);

        // Free run, period 10.
        t = cyc;
        period = 24'd10; run_en = 1'b1;
        expect_ev(K_LOAD, t + 11, 0, 1'b0, 2);
        expect_ev(K_LOAD, t + 21, 0, 1'b0, 3);
        expect_ev(K_LOAD, t + 31, 0, 1'b0, 4);
        repeat (32) tick();
        run_en = 1'b0;
        repeat (4) tick();
        check("gen_after_period10", 32'(gen_count), 4);

        // Free run, period 0: spacing limited to 2+SETTLE.
        t = cyc;
        period = 24'd0; run_en = 1'b1;
        expect_ev(K_LOAD, t + 2, 0, 1'b0, 5);
        expect_ev(K_LOAD, t + 6, 0, 1'b0, 6);
        expect_ev(K_LOAD, t + 10, 0, 1'b0, 7);
        repeat (11) tick();
        run_en = 1'b0; period = 24'd10;
        repeat (6) tick();
        check("gen_after_period0", 32'(gen_count), 7);
        check("idle_after_period0", 32'(busy), 0);

        // Clear and step together; edit waits for the clear to finish.
        t = cyc;
        expect_ev(K_CLEAR, t + 2, 0, 1'b0, 0);
        clear_req = 1'b1; step_req = 1'b1;
        tick();
        clear_req = 1'b0; step_req = 1'b0;
        edit_x = 8'd3; edit_y = 8'd1; edit_val = 1'b1; edit_valid = 1'b1;
        check("ready_low_clear_pend", 32'(edit_ready), 0);
        repeat (4) tick();
        check("ready_after_clear", 32'(edit_ready), 1);
        expect_ev(K_WE, cyc + 1, 83, 1'b1, 0);
        tick();
        edit_valid = 1'b0;
        repeat (4) tick();
        check("gen_after_clear", 32'(gen_count), 0);

        // Reset during SETTLE after a load drops the queued step.
        expect_ev(K_LOAD, cyc + 2, 0, 1'b0, 1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("busy_in_settle", 32'(busy), 1);
        reset = 1'b1;
        tick();
        check("midreset_busy", 32'(busy), 0);
        check("midreset_gen", 32'(gen_count), 0);
        check("midreset_outputs", 32'({grid_we, edit_err, grid_load_next, grid_clear, edit_ready}), 0);
        reset = 1'b0;
        repeat (8) tick();
        check("gen_after_midreset", 32'(gen_count), 0);
        check("idle_after_midreset", 32'(busy), 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
